rffe_spi_sequencer: RTL



---
 rtl/rffe_spi_seq_pkg.sv | 50 +++++
 rtl/rffe_spi_seq_bus_access.sv | 73 +++++++
 rtl/rffe_spi_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rffe_spi_seq_pkg.sv
// Shared types and register-map constants for the RFFE SPI command sequencer.
package rffe_spi_seq_pkg;

    typedef enum logic [3:0] {
        INIT_SS,
        INIT_CTL,
        IDLE,
        CLR_ST,
        SS_ON,
        TX,
        POLL_RX,
        RX,
        POLL_TMT,
        SS_OFF,
        RESP
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_STB1,
        PH_STB2,
        PH_GAP
    } bus_phase_e;

    typedef struct packed {
        seq_state_e state;
        bus_phase_e phase;
    } seq_dbg_t;

    // SPI master register addresses
    localparam logic [2:0] RXDATA  = 3'd0;
    localparam logic [2:0] TXDATA  = 3'd1;
    localparam logic [2:0] STATUS  = 3'd2;
    localparam logic [2:0] CONTROL = 3'd3;
    localparam logic [2:0] SSEL    = 3'd5;

    // status / control bit positions
    localparam int E    = 8;
    localparam int RRDY = 7;
    localparam int TMT  = 5;
    localparam int SSO  = 10;

    function automatic logic [15:0] ctl_word(input logic sso);
        logic [15:0] w;
        w      = '0;
        w[SSO] = sso;
        return w;
    endfunction

endpackage

// File: rtl/rffe_spi_seq_bus_access.sv
// One SPI-master register access: two strobe cycles with stable address/data,
// then a one-cycle gap with chip select low and both strobes high.
module rffe_spi_bus_access
    import rffe_spi_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rnw,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [15:0] rdata,
    output bus_phase_e  phase,
    output logic        spi_cs,
    output logic [2:0]  spi_addr,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata
);

    bus_phase_e phase_d;
    logic       start;

    // A new request is taken at the end of the gap, so accesses run back to back.
    always_comb begin
        phase_d = phase;
        start   = 1'b0;
        case (phase)
            PH_IDLE, PH_GAP: begin
                if (req) begin
                    phase_d = PH_STB1;
                    start   = 1'b1;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_STB1: phase_d = PH_STB2;
            PH_STB2: phase_d = PH_GAP;
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase       <= PH_IDLE;
            spi_cs      <= 1'b0;
            spi_read_n  <= 1'b1;
            spi_write_n <= 1'b1;
            spi_addr    <= '0;
            spi_wdata   <= '0;
        end else begin
            phase <= phase_d;
            if (start) begin
                spi_cs      <= 1'b1;
                spi_read_n  <= ~rnw;
                spi_write_n <= rnw;
                spi_addr    <= addr;
                spi_wdata   <= rnw ? 16'h0000 : wdata;
            end else if (phase == PH_STB2) begin
                spi_cs      <= 1'b0;
                spi_read_n  <= 1'b1;
                spi_write_n <= 1'b1;
            end
        end
    end

    // done marks the last strobe cycle; the caller samples rdata on the edge ending it.
    assign done  = (phase == PH_STB2);
    assign rdata = spi_rdata;

endmodule

// File: rtl/rffe_spi_sequencer.sv
// Command-driven sequencer in front of the RFFE SPI master control slave.
// Optional poll timeout abort is enabled by defining RFFE_SEQ_TIMEOUT_EN.
module rffe_spi_sequencer
    import rffe_spi_seq_pkg::*;
#(
    parameter int MAX_BYTES    = 4,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_nbytes,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    output logic                   rsp_valid,
    output logic [8*MAX_BYTES-1:0] rsp_data,
    output logic                   rsp_err,
    output logic                   spi_cs,
    output logic [2:0]             spi_addr,
    output logic                   spi_read_n,
    output logic                   spi_write_n,
    output logic [15:0]            spi_wdata,
    input  logic [15:0]            spi_rdata,
    output seq_dbg_t               dbg
);

    localparam int         IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [2:0] MAX_NB = 3'(MAX_BYTES);

    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, last_q;
    logic [8*MAX_BYTES-1:0] tx_buf_q, rx_buf_q;
    logic                   err_q;
    logic                   acc_req, acc_rnw, acc_done;
    logic [2:0]             acc_addr;
    logic [15:0]            acc_wdata, acc_rdata;
    bus_phase_e             bus_phase;
    logic                   accept, bad_len, timeout_hit, poll_abort;
    logic [7:0]             tx_byte;
    logic                   unused_rdata;

    assign accept       = (state_q == IDLE) && cmd_valid;
    assign bad_len      = (cmd_nbytes == 3'd0) || (cmd_nbytes > MAX_NB);
    assign tx_byte      = tx_buf_q[{idx_q, 3'b000} +: 8];
    assign unused_rdata = ^acc_rdata[15:9];
    assign dbg          = {state_q, bus_phase};

`ifdef RFFE_SEQ_TIMEOUT_EN
    localparam int PC_W = $clog2(POLL_TIMEOUT + 1);
    logic [PC_W-1:0] poll_cnt_q;
    logic            in_poll;

    assign in_poll = (state_q == POLL_RX) || (state_q == POLL_TMT);

    // Cleared outside the poll states, so every poll loop starts from zero.
    always_ff @(posedge clk) begin
        if (!reset_n || !in_poll) begin
            poll_cnt_q <= '0;
        end else if (acc_done) begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (poll_cnt_q == PC_W'(POLL_TIMEOUT - 1));
`else
    localparam int unused_poll_timeout = POLL_TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        acc_req    = 1'b0;
        acc_rnw    = 1'b0;
        acc_addr   = RXDATA;
        acc_wdata  = 16'h0000;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        poll_abort = 1'b0;
        case (state_q)
            INIT_SS: begin
                acc_req   = 1'b1;
                acc_addr  = SSEL;
                acc_wdata = 16'h0001;
                if (acc_done) state_d = INIT_CTL;
            end
            INIT_CTL: begin
                acc_req   = 1'b1;
                acc_addr  = CONTROL;
                acc_wdata = ctl_word(1'b0);
                if (acc_done) state_d = IDLE;
            end
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = bad_len ? RESP : CLR_ST;
            end
            CLR_ST: begin
                acc_req  = 1'b1;
                acc_addr = STATUS;
                if (acc_done) state_d = SS_ON;
            end
            SS_ON: begin
                acc_req   = 1'b1;
                acc_addr  = CONTROL;
                acc_wdata = ctl_word(1'b1);
                if (acc_done) state_d = TX;
            end
            TX: begin
                acc_req   = 1'b1;
                acc_addr  = TXDATA;
                acc_wdata = {8'h00, tx_byte};
                if (acc_done) state_d = POLL_RX;
            end
            POLL_RX: begin
                acc_req  = 1'b1;
                acc_rnw  = 1'b1;
                acc_addr = STATUS;
                if (acc_done) begin
                    if (acc_rdata[RRDY]) begin
                        state_d = RX;
                    end else if (timeout_hit) begin
                        poll_abort = 1'b1;
                        state_d    = SS_OFF;
                    end
                end
            end
            RX: begin
                acc_req  = 1'b1;
                acc_rnw  = 1'b1;
                acc_addr = RXDATA;
                if (acc_done) state_d = (idx_q == last_q) ? POLL_TMT : TX;
            end
            POLL_TMT: begin
                acc_req  = 1'b1;
                acc_rnw  = 1'b1;
                acc_addr = STATUS;
                if (acc_done) begin
                    if (acc_rdata[TMT]) begin
                        state_d = SS_OFF;
                    end else if (timeout_hit) begin
                        poll_abort = 1'b1;
                        state_d    = SS_OFF;
                    end
                end
            end
            SS_OFF: begin
                acc_req   = 1'b1;
                acc_addr  = CONTROL;
                acc_wdata = ctl_word(1'b0);
                if (acc_done) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = INIT_SS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= INIT_SS;
            idx_q    <= '0;
            last_q   <= '0;
            tx_buf_q <= '0;
            rx_buf_q <= '0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tx_buf_q <= cmd_data;
                last_q   <= IDX_W'(cmd_nbytes - 3'd1);
                idx_q    <= '0;
                rx_buf_q <= '0;
                err_q    <= 1'b0;
            end
            if (state_q == POLL_RX && acc_done && acc_rdata[E]) err_q <= 1'b1;
            if (poll_abort) err_q <= 1'b1;
            if (state_q == RX && acc_done) begin
                rx_buf_q[{idx_q, 3'b000} +: 8] <= acc_rdata[7:0];
                if (idx_q != last_q) idx_q <= idx_q + 1'b1;
            end
            // Response fields are captured on entry to RESP and held until the next one.
            if (state_d == RESP && state_q != RESP) begin
                if (state_q == IDLE) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    rsp_data <= rx_buf_q;
                    rsp_err  <= err_q;
                end
            end
        end
    end

    rffe_spi_bus_access u_bus (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (acc_req),
        .rnw         (acc_rnw),
        .addr        (acc_addr),
        .wdata       (acc_wdata),
        .done        (acc_done),
        .rdata       (acc_rdata),
        .phase       (bus_phase),
        .spi_cs      (spi_cs),
        .spi_addr    (spi_addr),
        .spi_read_n  (spi_read_n),
        .spi_write_n (spi_write_n),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata)
    );

endmodule
